// File: rtl/shader_pkg.sv
// Shared definitions for the shader program memory slice.
//   DEFAULT_INSTR_WIDTH / DEFAULT_NUM_INSTR : default geometry
//   instr_t                                 : one instruction word at default width
//   pc_width()                              : width of a program-counter / index field
package shader_pkg;

  localparam int DEFAULT_INSTR_WIDTH = 8;
  localparam int DEFAULT_NUM_INSTR   = 16;

  typedef logic [DEFAULT_INSTR_WIDTH-1:0] instr_t;

  // Index width for an n-entry store; never narrower than one bit.
  function automatic int pc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/instr_shift_reg.sv
// N-deep word shift register used for both program buffers.
//   clk_i, rst_i   : clock, async active-high reset (loads INIT)
//   shift_en_i     : shift toward word 0, shift_din_i enters word DEPTH-1
//   rotate_en_i    : rotate toward word 0, word 0 wraps to word DEPTH-1
//   load_en_i      : parallel load of load_din_i
//   q_o            : current contents, word i at q_o[i]
// Priority: load > rotate > shift.
module instr_shift_reg #(
  parameter int                   DEPTH = 16,
  parameter int                   W     = 8,
  parameter logic [DEPTH*W-1:0]   INIT  = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      shift_en_i,
  input  logic [W-1:0]              shift_din_i,
  input  logic                      rotate_en_i,
  input  logic                      load_en_i,
  input  logic [DEPTH-1:0][W-1:0]   load_din_i,
  output logic [DEPTH-1:0][W-1:0]   q_o
);

  logic [DEPTH-1:0][W-1:0] q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            q <= INIT;
    else if (load_en_i)   q <= load_din_i;
    else if (rotate_en_i) q <= {q[0], q[DEPTH-1:1]};
    else if (shift_en_i)  q <= {shift_din_i, q[DEPTH-1:1]};
  end

  assign q_o = q;

endmodule

// File: rtl/shader_program_memory.sv
// Double-buffered shader instruction store.
//   clk_i, rst_i     : clock, async active-high reset
//   spi_instr_i      : instruction byte from the SPI receiver
//   spi_shift_i      : shift pulse; with spi_load_i pushes spi_instr_i into the shadow tail
//   spi_load_i       : qualifies spi_shift_i
//   frame_start_i    : frame boundary; swaps in a complete shadow program
//   exec_shift_i     : core advance, rotates the active buffer
//   instr_o, pc_o    : current instruction (active word 0) and its index
//   last_o           : pc_o at the final instruction
//   pending_o        : complete shadow program awaiting a frame boundary
//   swapped_o        : pulse the cycle after a swap
module shader_program_memory
  import shader_pkg::*;
#(
  parameter int                           NUM_INSTR    = DEFAULT_NUM_INSTR,
  parameter int                           INSTR_WIDTH  = DEFAULT_INSTR_WIDTH,
  parameter logic [NUM_INSTR*INSTR_WIDTH-1:0] INIT_PROGRAM = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [INSTR_WIDTH-1:0]           spi_instr_i,
  input  logic                             spi_shift_i,
  input  logic                             spi_load_i,
  input  logic                             frame_start_i,
  input  logic                             exec_shift_i,
  output logic [INSTR_WIDTH-1:0]           instr_o,
  output logic [pc_width(NUM_INSTR)-1:0]   pc_o,
  output logic                             last_o,
  output logic                             pending_o,
  output logic                             swapped_o
);

  localparam int PCW = pc_width(NUM_INSTR);
  localparam int CW  = $clog2(NUM_INSTR + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(NUM_INSTR);
  localparam logic [PCW-1:0] PC_LAST  = PCW'(NUM_INSTR - 1);

  logic [NUM_INSTR-1:0][INSTR_WIDTH-1:0] shadow_q, active_q;
  logic [CW-1:0]  load_cnt;
  logic [PCW-1:0] pc;
  logic           spi_push, swap, swapped_q;

  assign spi_push  = spi_shift_i & spi_load_i;
  assign pending_o = (load_cnt == CNT_FULL);
  assign swap      = frame_start_i & pending_o;

  // Shadow only ever shifts in; a push in the swap cycle still lands here
  // after active has captured the pre-push contents.
  instr_shift_reg #(
    .DEPTH (NUM_INSTR),
    .W     (INSTR_WIDTH),
    .INIT  ('0)
  ) u_shadow (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .shift_en_i  (spi_push),
    .shift_din_i (spi_instr_i),
    .rotate_en_i (1'b0),
    .load_en_i   (1'b0),
    .load_din_i  ('0),
    .q_o         (shadow_q)
  );

  // Load has priority over rotate, so a swap drops a coincident exec shift.
  instr_shift_reg #(
    .DEPTH (NUM_INSTR),
    .W     (INSTR_WIDTH),
    .INIT  (INIT_PROGRAM)
  ) u_active (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .shift_en_i  (1'b0),
    .shift_din_i ('0),
    .rotate_en_i (exec_shift_i),
    .load_en_i   (swap),
    .load_din_i  (shadow_q),
    .q_o         (active_q)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      load_cnt  <= '0;
      pc        <= '0;
      swapped_q <= 1'b0;
    end else begin
      swapped_q <= swap;
      if (swap)                       load_cnt <= spi_push ? CW'(1) : '0;
      else if (spi_push && !pending_o) load_cnt <= load_cnt + CW'(1);
      if (swap)              pc <= '0;
      else if (exec_shift_i) pc <= (pc == PC_LAST) ? '0 : pc + PCW'(1);
    end
  end

  assign instr_o   = active_q[0];
  assign pc_o      = pc;
  assign last_o    = (pc == PC_LAST);
  assign swapped_o = swapped_q;

endmodule

// File: tb/tb_shader_program_memory.sv
module tb_shader_program_memory;
  import shader_pkg::*;

  localparam int N = 4;

  logic       clk = 0;
  logic       rst = 1;
  logic [7:0] spi_instr = '0;
  logic       spi_shift = 0, spi_load = 0, frame_start = 0, exec_shift = 0;
  logic [7:0] instr;
  logic [1:0] pc;
  logic       last, pending, swapped;

  int n_chk = 0, n_pass = 0;

  // behavioural model
  int m_act[N];
  int m_shd[N];
  int m_cnt, m_pc;
  bit m_swapped;

  shader_program_memory #(
    .NUM_INSTR    (N),
    .INSTR_WIDTH  (8),
    .INIT_PROGRAM (32'h04030201)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .spi_instr_i   (spi_instr),
    .spi_shift_i   (spi_shift),
    .spi_load_i    (spi_load),
    .frame_start_i (frame_start),
    .exec_shift_i  (exec_shift),
    .instr_o       (instr),
    .pc_o          (pc),
    .last_o        (last),
    .pending_o     (pending),
    .swapped_o     (swapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic m_reset();
    m_act[0] = 'h01; m_act[1] = 'h02; m_act[2] = 'h03; m_act[3] = 'h04;
    foreach (m_shd[i]) m_shd[i] = 0;
    m_cnt = 0; m_pc = 0; m_swapped = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".instr"},   int'(instr),   m_act[0]);
    chk({tag, ".pc"},      int'(pc),      m_pc);
    chk({tag, ".last"},    int'(last),    int'(m_pc == N-1));
    chk({tag, ".pending"}, int'(pending), int'(m_cnt == N));
    chk({tag, ".swapped"}, int'(swapped), int'(m_swapped));
  endtask

  // One clock with the given inputs; model advances by the stated rules.
  task automatic step(input string tag, input bit sh, input bit ld, input logic [7:0] d,
                      input bit fs, input bit ex);
    int  tmp;
    bit  do_swap;
    spi_shift = sh; spi_load = ld; spi_instr = d; frame_start = fs; exec_shift = ex;
    do_swap = fs && (m_cnt == N);
    m_swapped = do_swap;
    if (do_swap) begin
      foreach (m_act[i]) m_act[i] = m_shd[i];
      m_pc = 0;
    end else if (ex) begin
      tmp = m_act[0];
      for (int i = 0; i < N-1; i++) m_act[i] = m_act[i+1];
      m_act[N-1] = tmp;
      m_pc = (m_pc + 1) % N;
    end
    if (do_swap) m_cnt = 0;
    if (sh && ld) begin
      for (int i = 0; i < N-1; i++) m_shd[i] = m_shd[i+1];
      m_shd[N-1] = int'(d);
      m_cnt = (m_cnt < N) ? m_cnt + 1 : N;
    end
    @(posedge clk);
    #1;
    spi_shift = 0; spi_load = 0; frame_start = 0; exec_shift = 0;
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic push(input string tag, input logic [7:0] d);
    step(tag, 1, 1, d, 0, 0);
  endtask

  initial begin
    m_reset();
    #12;
    chk_all("reset");
    @(negedge clk);
    rst = 0;

    // rotation through the init program
    for (int i = 0; i < 5; i++) step("rot", 0, 0, 0, 0, 1);

    // stray pulses with no effect
    step("shift_only", 1, 0, 8'hEE, 0, 0);
    step("load_only",  0, 1, 8'hEE, 0, 0);

    // full load then swap
    push("ldA0", 8'hA0); push("ldA1", 8'hA1); push("ldA2", 8'hA2); push("ldA3", 8'hA3);
    step("swapA", 0, 0, 0, 1, 0);
    step("postA", 0, 0, 0, 0, 0);
    chk("swapA.instr_const", int'(instr), 'hA0);

    // partial load never swaps
    push("p0", 8'h10); push("p1", 8'h11); push("p2", 8'h12);
    step("partial_fs", 0, 0, 0, 1, 0);
    push("p3", 8'h13);
    chk("partial.pending_const", int'(pending), 1);
    step("swapP", 0, 0, 0, 1, 0);

    // overrun: last N bytes win
    for (int i = 0; i < 6; i++) push("ldB", 8'hB0 + 8'(i));
    step("swapB", 0, 0, 0, 1, 0);
    chk("swapB.instr_const", int'(instr), 'hB2);
    for (int i = 0; i < 3; i++) step("rotB", 0, 0, 0, 0, 1);
    chk("rotB.instr_const", int'(instr), 'hB5);

    // swap + exec + load in the same cycle
    for (int i = 0; i < 4; i++) push("ldD", 8'hD0 + 8'(i));
    step("rot_pre", 0, 0, 0, 0, 1);
    step("triple", 1, 1, 8'hC0, 1, 1);
    chk("triple.pc_const", int'(pc), 0);
    chk("triple.instr_const", int'(instr), 'hD0);
    for (int i = 0; i < 3; i++) push("ldC", 8'hC1 + 8'(i));
    chk("triple.cnt_pending", int'(pending), 1);
    step("swapC", 0, 0, 0, 1, 0);
    chk("swapC.instr_const", int'(instr), 'hC0);

    // async reset mid-load and mid-rotation
    push("r0", 8'h55); push("r1", 8'h66);
    step("rrot", 0, 0, 0, 0, 1);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    m_reset();
    chk_all("async_rst");
    @(negedge clk);
    rst = 0;
    step("rst_fs", 0, 0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step("rand", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
           8'($urandom), ($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/shader_program_memory.md
Name: shader_program_memory

Overview:
- Instruction store that sits directly downstream of the SPI command receiver.
- The SPI side pushes 8-bit instruction bytes into a shadow buffer using load/shift pulses.
- The shader core executes from a separate active buffer, which is a circular rotating store.
- A completed shadow program is copied into the active buffer only at a frame boundary, so a program is never swapped in mid-frame (no tearing).

Parameters:
- NUM_INSTR, 16, program length in instructions; must be at least 2.
- INSTR_WIDTH, 8, instruction width in bits.
- INIT_PROGRAM, '0, value of the active buffer at reset; word i is at bits [i*INSTR_WIDTH +: INSTR_WIDTH].

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- spi_instr_i  in  INSTR_WIDTH  instruction byte from the SPI receiver.
- spi_shift_i  in  1  one-cycle pulse: shift the shadow buffer.
- spi_load_i  in  1  one-cycle pulse, qualifies spi_shift_i: spi_instr_i enters the shadow tail.
- frame_start_i  in  1  one-cycle pulse at frame start, from the timing generator.
- exec_shift_i  in  1  core advance: rotate the active buffer by one.
- instr_o  out  INSTR_WIDTH  current instruction (active word 0).
- pc_o  out  $clog2(NUM_INSTR)  index of the current instruction.
- last_o  out  1  high when pc_o == NUM_INSTR-1.
- pending_o  out  1  a complete shadow program is waiting for a swap.
- swapped_o  out  1  one-cycle pulse in the cycle after a swap.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - active = INIT_PROGRAM, shadow = 0, load_cnt = 0, pc = 0.
  - Outputs: pending_o = 0, swapped_o = 0, instr_o = INIT word 0, last_o = 0.
  - Reset asserted mid-program discards all partial shadow content.
- Shadow buffer:
  - On spi_shift_i && spi_load_i: shadow[k] <= shadow[k+1] for k < N-1, and shadow[N-1] <= spi_instr_i.
  - load_cnt increments and saturates at NUM_INSTR.
  - spi_shift_i without spi_load_i: no effect.
  - spi_load_i without spi_shift_i: ignored.
  - After NUM_INSTR loads, shadow[0] holds the first byte sent.
- pending_o = (load_cnt == NUM_INSTR), combinational from the register.
  - Loads beyond NUM_INSTR keep shifting, so the last NUM_INSTR bytes win; pending_o stays 1.
- Active buffer:
  - On exec_shift_i: rotate, so active[k] <= active[k+1] and active[N-1] <= active[0].
  - pc increments, wrapping from N-1 to 0.
  - instr_o = active[0] and last_o are combinational from registers, with zero latency relative to the rotation edge.
  - The core is responsible for issuing a multiple of NUM_INSTR shifts per frame. The block does not realign pc.
- Swap occurs on frame_start_i && pending_o:
  - active <= shadow, pc <= 0, load_cnt <= 0.
  - swapped_o is 1 in the next cycle only.
- frame_start_i without pending_o: no effect (partial programs are never swapped).
- Simultaneous events:
  - Swap and exec_shift_i in the same cycle: the swap wins and the shift is dropped.
  - Swap and an SPI load in the same cycle: active takes the pre-load shadow. The shadow then shifts in the new byte and load_cnt becomes 1.
  - exec_shift_i and an SPI load together: the two proceed independently.
- All state updates happen on the clk_i rising edge. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package shader_pkg:
  - INSTR_WIDTH and NUM_INSTR default constants.
  - typedef instr_t (logic [INSTR_WIDTH-1:0]).
  - The pc width function.
- One sub-module, instr_shift_reg: an N-deep word shift register with shift-in, rotate, and parallel-load modes.
  - Instantiated twice: once as shadow (shift-in) and once as active (rotate plus parallel load).
- Counters, the swap logic and the flags stay in the top level.

Test Plan:
- Reset with NUM_INSTR=4 and INIT_PROGRAM = {8'h04, 8'h03, 8'h02, 8'h01} (word 0 = 8'h01): issue 5 exec_shift_i pulses -> instr_o sequence 01, 02, 03, 04, 01 and pc_o sequence 0, 1, 2, 3, 0. last_o is high only at pc=3.
- Load bytes A0, A1, A2, A3 via SPI, then pulse frame_start_i -> pending_o rises after the 4th load. swapped_o pulses one cycle after frame_start_i; instr_o=A0, pc_o=0, pending_o=0.
- Load only 3 bytes, then pulse frame_start_i -> no swap, swapped_o stays 0, active program unchanged. A 4th load then sets pending_o.
- Load 6 bytes B0..B5, then swap -> active holds B2, B3, B4, B5.
- Pending program, then frame_start_i, exec_shift_i and an SPI load of C0 in the same cycle -> pc_o=0, instr_o = new word 0, shift dropped, load_cnt = 1.
- Assert rst_i asynchronously after 2 of 4 loads and mid-rotation -> outputs return to reset values immediately. A later frame_start_i causes no swap.
